// File: rtl/fifo_wr_ctrl.sv
// Write-side front end of the pixel line FIFO: turns a non-stallable pixel stream into
// FIFO writes, dropping the remainder of a line on overflow, with position and drop stats.
module fifo_wr_ctrl #(
  parameter int unsigned DATA_WD   = 10,
  parameter int unsigned PTR_WD    = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LINE_PIX  = 640,
  parameter int unsigned AF_THRESH = 960
) (
  input  logic               w_clk_i,
  input  logic               w_rst_ni,
  input  logic               pix_valid_i,
  input  logic [DATA_WD-1:0] pix_data_i,
  input  logic               sof_i,
  input  logic               clr_ovf_i,
  input  logic               full_i,
  input  logic [PTR_WD-1:0]  data_cnt_w_i,
  output logic               w_en_o,
  output logic [DATA_WD-1:0] w_data_o,
  output logic               almost_full_o,
  output logic               overflow_o,
  output logic [15:0]        drop_cnt_o,
  output logic [9:0]         pix_x_o,
  output logic [9:0]         line_cnt_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP_LINE} state_e;

  localparam logic [9:0]      LAST_X  = 10'(LINE_PIX - 1);
  localparam logic [PTR_WD:0] CNT_LIM = (PTR_WD + 1)'(DEPTH - 2);
  localparam logic [PTR_WD:0] AF_LIM  = (PTR_WD + 1)'(AF_THRESH);

  state_e             state_q, state_d, eval_state;
  logic [9:0]         x_q, x_d, line_q, line_d, pix_x_q, pix_x_d, cur_x, cur_line;
  logic               wen_q, wen_d, af_q, af_d, ovf_q, ovf_d;
  logic [DATA_WD-1:0] wdata_q, wdata_d;
  logic [15:0]        drop_q, drop_d;
  logic               space_ok, take, drop;

  assign space_ok = !full_i && ({1'b0, data_cnt_w_i} < CNT_LIM);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    line_d     = line_q;
    pix_x_d    = pix_x_q;
    wen_d      = 1'b0;
    wdata_d    = wdata_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    drop       = 1'b0;
    af_d       = full_i || ({1'b0, data_cnt_w_i} >= AF_LIM);
    take       = pix_valid_i && (sof_i || (state_q != IDLE));
    // A SOF pixel restarts position and is judged as if already ACTIVE.
    eval_state = sof_i ? ACTIVE : state_q;
    cur_x      = sof_i ? '0 : x_q;
    cur_line   = sof_i ? '0 : line_q;

    if (take) begin
      if ((eval_state == ACTIVE) && space_ok) begin
        wen_d   = 1'b1;
        wdata_d = pix_data_i;
        state_d = ACTIVE;
      end else begin
        drop    = 1'b1;
        state_d = DROP_LINE;
      end
      pix_x_d = cur_x;
      // End of line always re-arms writing, even if its last pixel was dropped.
      if (cur_x == LAST_X) begin
        x_d     = '0;
        line_d  = cur_line + 10'd1;
        state_d = ACTIVE;
      end else begin
        x_d    = cur_x + 10'd1;
        line_d = cur_line;
      end
    end

    if (clr_ovf_i) begin
      ovf_d  = drop;
      drop_d = {15'd0, drop};
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge w_clk_i) begin
    if (!w_rst_ni) begin
      state_q <= IDLE;
      x_q     <= '0;
      line_q  <= '0;
      pix_x_q <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      line_q  <= line_d;
      pix_x_q <= pix_x_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign w_en_o        = wen_q;
  assign w_data_o      = wdata_q;
  assign almost_full_o = af_q;
  assign overflow_o    = ovf_q;
  assign drop_cnt_o    = drop_q;
  assign pix_x_o       = pix_x_q;
  assign line_cnt_o    = line_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Randomized bench for fifo_wr_ctrl, compared every cycle against a per-pixel line model.
module tb_fifo_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, valid, sof, clr, full;
  logic [9:0]  data, cnt;
  logic        w_en, af, ovf;
  logic [9:0]  w_data, pix_x, line_cnt;
  logic [15:0] drop_cnt;

  int unsigned checks = 0, failures = 0;

  // reference state: in_frame / dropping flags and position of the next pixel
  bit          m_in_frame, m_dropping;
  int unsigned m_pos, m_line;
  bit          e_wen, e_af, e_ovf;
  int unsigned e_wdata, e_drop, e_x;

  always #5 clk = ~clk;

  fifo_wr_ctrl #(.DATA_WD(10), .PTR_WD(10), .DEPTH(1024), .LINE_PIX(640), .AF_THRESH(960)) dut (
    .w_clk_i(clk), .w_rst_ni(rst_n), .pix_valid_i(valid), .pix_data_i(data), .sof_i(sof),
    .clr_ovf_i(clr), .full_i(full), .data_cnt_w_i(cnt), .w_en_o(w_en), .w_data_o(w_data),
    .almost_full_o(af), .overflow_o(ovf), .drop_cnt_o(drop_cnt), .pix_x_o(pix_x),
    .line_cnt_o(line_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input int unsigned d, input bit s,
                       input bit c, input bit f, input int unsigned n);
    bit dropped = 0;
    if (r) begin
      m_in_frame = 0; m_dropping = 0; m_pos = 0; m_line = 0;
      e_wen = 0; e_af = 0; e_ovf = 0; e_wdata = 0; e_drop = 0; e_x = 0;
      return;
    end
    e_af  = f || (n >= 960);
    e_wen = 0;
    if (v && (s || m_in_frame)) begin
      if (s) begin m_in_frame = 1; m_dropping = 0; m_pos = 0; m_line = 0; end
      if (!m_dropping && !f && n < 1022) begin
        e_wen = 1; e_wdata = d;
      end else begin
        dropped = 1; m_dropping = 1;
      end
      e_x = m_pos;
      if (m_pos == 639) begin
        m_pos = 0; m_line = (m_line + 1) % 1024; m_dropping = 0;
      end else m_pos++;
    end
    if (c) begin
      e_ovf = dropped; e_drop = dropped;
    end else if (dropped) begin
      e_ovf = 1; if (e_drop < 65535) e_drop++;
    end
  endtask

  // Drive one cycle's inputs, advance the model, then sample 1 time unit after the edge.
  task automatic cyc(input bit r, input bit v, input int unsigned d, input bit s,
                     input bit c, input bit f, input int unsigned n, input bit full_chk = 1);
    rst_n = !r; valid = v; data = 10'(d); sof = s; clr = c; full = f; cnt = 10'(n);
    model(r, v, d, s, c, f, n);
    @(posedge clk); #1;
    chk("w_en", 32'(w_en), 32'(e_wen));
    chk("w_data", 32'(w_data), e_wdata);
    if (full_chk) begin
      chk("almost_full", 32'(af), 32'(e_af));
      chk("overflow", 32'(ovf), 32'(e_ovf));
      chk("drop_cnt", 32'(drop_cnt), e_drop);
      chk("pix_x", 32'(pix_x), e_x);
      chk("line_cnt", 32'(line_cnt), m_line);
    end
  endtask

  initial begin
    rst_n = 0; valid = 0; data = '0; sof = 0; clr = 0; full = 0; cnt = '0;
    @(posedge clk); #1;

    // reset with valid held high, then pixels without SOF stay ignored
    cyc(1, 1, 5, 0, 0, 0, 0);
    cyc(1, 1, 6, 0, 0, 0, 0);
    chk("rst_w_en", 32'(w_en), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, $urandom_range(0, 1023), 0, 0, 0, 0);
    chk("idle_w_en", 32'(w_en), 0);

    // basic line, data = x
    for (int i = 0; i < 640; i++) cyc(0, 1, i, i == 0, 0, 0, 0);
    chk("basic_line_cnt", 32'(line_cnt), 1);
    chk("basic_last_data", 32'(w_data), 639);

    // gapped 1-in-3 stream with random data and occupancy
    for (int i = 0; i < 300; i++)
      cyc(0, (i % 3) == 0, $urandom_range(0, 1023), 0, 0, 0, $urandom_range(0, 1000));

    // fresh line with overflow at pixel 100
    for (int i = 0; i < 640; i++) cyc(0, 1, i, i == 0, 0, 0, (i == 100) ? 1022 : 0);
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_drop540", 32'(drop_cnt), 540);
    for (int i = 0; i < 10; i++) cyc(0, 1, $urandom_range(0, 1023), 0, 0, 0, 0);
    chk("ovf_resume", 32'(w_en), 1);

    // full for 5 cycles mid-line, then space returns but line stays dropped
    for (int i = 0; i < 5; i++) cyc(0, 1, $urandom_range(0, 1023), 0, 0, 1, 0);
    chk("full_no_wen", 32'(w_en), 0);
    cyc(0, 1, 77, 0, 0, 0, 0);
    chk("full_drop_line", 32'(w_en), 0);
    chk("full_drop_cnt", 32'(drop_cnt), 546);

    // saturation: clear, then 65534 drops to reach FFFE, then 3 more
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 65534; i++) cyc(0, 1, i % 1024, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("sat_fffe", 32'(drop_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) cyc(0, 1, 3, 0, 0, 1, 0);
    chk("sat_ffff", 32'(drop_cnt), 32'hFFFF);
    cyc(0, 1, 3, 0, 1, 1, 0);
    chk("clr_drop_ovf", 32'(ovf), 1);
    chk("clr_drop_cnt", 32'(drop_cnt), 1);

    // SOF mid-line while dropping at x=300
    for (int i = 0; i < 300; i++) cyc(0, 1, i, i == 0, 0, i == 10, 0);
    cyc(0, 1, 9, 1, 0, 0, 0);
    chk("sof_x", 32'(pix_x), 0);
    chk("sof_line", 32'(line_cnt), 0);
    chk("sof_w_en", 32'(w_en), 1);

    // random mix, occasional reset
    for (int i = 0; i < 4000; i++) begin
      bit f = ($urandom_range(0, 49) == 0);
      int unsigned n = f ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(950, 1023)
                                                           : $urandom_range(0, 950));
      cyc($urandom_range(0, 799) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1023),
          $urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0, f, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
